// File: rtl/risc_boot_pkg.sv
// Shared types and constants for the RISC boot loader and the core it feeds.
package risc_boot_pkg;

    // Defaults must track the core's memory geometry.
    localparam int unsigned DEF_AWIDTH = 5;
    localparam int unsigned DEF_DWIDTH = 8;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StLoad = 3'd1,
        StHold = 3'd2,
        StRun  = 3'd3,
        StDone = 3'd4
    } boot_state_e;

endpackage

// File: rtl/risc_boot_loader_if.sv
// Program-word stream into the boot loader: valid/ready handshake.
interface risc_boot_loader_if #(
    parameter int unsigned DWIDTH = risc_boot_pkg::DEF_DWIDTH
) ();

    logic              in_valid;
    logic [DWIDTH-1:0] in_data;
    logic              in_ready;

    // Upstream source of program words.
    modport master (output in_valid, output in_data, input in_ready);
    // Loader side.
    modport slave (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/risc_boot_loader_counter.sv
// Up-counter with synchronous load and count enable.
module risc_boot_loader_counter #(
    parameter int unsigned WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    // Load has priority over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (en) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/risc_boot_loader.sv
// Boot loader: streams program words into core memory from address 0, holds the
// core in reset during the load plus a short settle time, then runs it until halt.
module risc_boot_loader import risc_boot_pkg::*; #(
    parameter int unsigned AWIDTH      = DEF_AWIDTH,
    parameter int unsigned DWIDTH      = DEF_DWIDTH,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AWIDTH:0]   len,
    risc_boot_loader_if.slave in_if,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_data,
    output logic              mem_wr,
    output logic              mem_own,
    output logic              cpu_rst,
    input  logic              cpu_halt,
    output logic              busy,
    output logic              done
);

    localparam int unsigned     HoldW    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HoldW-1:0] HoldInit = HoldW'(HOLD_CYCLES - 1);
    localparam logic [AWIDTH:0]  FullLen  = {1'b1, {AWIDTH{1'b0}}};

    boot_state_e       state_q, state_d;
    logic [AWIDTH:0]   len_q, len_d, len_eff;
    logic [AWIDTH:0]   cnt_q;
    logic              cnt_load, cnt_en;
    logic [HoldW-1:0]  hold_q, hold_d;
    logic              xfer, last;

    logic              in_ready_q, in_ready_d;
    logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DWIDTH-1:0] mem_data_q, mem_data_d;
    logic              mem_wr_q, mem_wr_d;
    logic              mem_own_q, mem_own_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Zero means a full memory; oversize requests are clamped so the address never wraps.
    assign len_eff = (len == '0 || len > FullLen) ? FullLen : len;

    // Transfers counted so far; its low bits are the next write address.
    risc_boot_loader_counter #(
        .WIDTH (AWIDTH + 1)
    ) u_word_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val ('0),
        .en       (cnt_en),
        .count    (cnt_q)
    );

    assign xfer = in_if.in_valid && in_ready_q;
    assign last = (cnt_q + (AWIDTH + 1)'(1)) == len_q;

    // Next state, counters and registered output values.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        hold_d     = hold_q;
        cnt_load   = 1'b0;
        cnt_en     = 1'b0;
        mem_wr_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d  = StLoad;
                    len_d    = len_eff;
                    cnt_load = 1'b1;
                end
            end
            StLoad: begin
                if (xfer) begin
                    mem_wr_d   = 1'b1;
                    mem_addr_d = cnt_q[AWIDTH-1:0];
                    mem_data_d = in_if.in_data;
                    cnt_en     = 1'b1;
                    if (last) begin
                        state_d = StHold;
                        hold_d  = HoldInit;
                    end
                end
            end
            StHold: begin
                if (hold_q == '0) begin
                    state_d = StRun;
                end else begin
                    hold_d = hold_q - HoldW'(1);
                end
            end
            StRun: begin
                if (cpu_halt) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs follow the state being entered so they are all registered.
        in_ready_d = (state_d == StLoad);
        cpu_rst_d  = (state_d == StIdle) || (state_d == StLoad) || (state_d == StHold);
        mem_own_d  = cpu_rst_d;
        busy_d     = (state_d == StLoad) || (state_d == StHold) || (state_d == StRun);
        done_d     = (state_d == StDone);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            len_q      <= '0;
            hold_q     <= '0;
            in_ready_q <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_wr_q   <= 1'b0;
            mem_own_q  <= 1'b1;
            cpu_rst_q  <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            hold_q     <= hold_d;
            in_ready_q <= in_ready_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            mem_wr_q   <= mem_wr_d;
            mem_own_q  <= mem_own_d;
            cpu_rst_q  <= cpu_rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign in_if.in_ready = in_ready_q;
    assign mem_addr       = mem_addr_q;
    assign mem_data       = mem_data_q;
    assign mem_wr         = mem_wr_q;
    assign mem_own        = mem_own_q;
    assign cpu_rst        = cpu_rst_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_risc_boot_loader.sv
// Bench for risc_boot_loader: directed scenarios plus randomized loads, checked
// every cycle against a transaction-level model and a log of observed writes.
module tb_risc_boot_loader;

    localparam int AW = 5;
    localparam int DW = 8;
    localparam int HC = 4;
    localparam int FULL = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          cpu_halt = 1'b0;
    logic [AW:0]   len = '0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_wr, mem_own, cpu_rst, busy, done;

    risc_boot_loader_if #(.DWIDTH(DW)) in_if ();

    risc_boot_loader #(
        .AWIDTH      (AW),
        .DWIDTH      (DW),
        .HOLD_CYCLES (HC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len      (len),
        .in_if    (in_if),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_wr   (mem_wr),
        .mem_own  (mem_own),
        .cpu_rst  (cpu_rst),
        .cpu_halt (cpu_halt),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int PIdle = 0, PLoad = 1, PHold = 2, PRun = 3, PDone = 4;
    int            m_phase, m_left, m_addr, m_hold;
    logic          e_ready, e_wr, e_rst, e_own, e_busy, e_done;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;

    task automatic model_outputs();
        e_ready = (m_phase == PLoad);
        e_rst   = (m_phase == PIdle) || (m_phase == PLoad) || (m_phase == PHold);
        e_own   = e_rst;
        e_busy  = (m_phase == PLoad) || (m_phase == PHold) || (m_phase == PRun);
        e_done  = (m_phase == PDone);
    endtask

    task automatic model_reset();
        m_phase = PIdle;
        m_left  = 0;
        m_addr  = 0;
        m_hold  = 0;
        e_wr    = 1'b0;
        e_addr  = '0;
        e_data  = '0;
        model_outputs();
    endtask

    task automatic model_step();
        e_wr = 1'b0;
        case (m_phase)
            PIdle, PDone: begin
                if (start) begin
                    m_phase = PLoad;
                    m_addr  = 0;
                    m_left  = (len == 0 || int'(len) > FULL) ? FULL : int'(len);
                end
            end
            PLoad: begin
                // e_ready still holds the value visible during the cycle just ended.
                if (in_if.in_valid && e_ready) begin
                    e_wr   = 1'b1;
                    e_addr = m_addr[AW-1:0];
                    e_data = in_if.in_data;
                    m_addr++;
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = PHold;
                        m_hold  = HC;
                    end
                end
            end
            PHold: begin
                m_hold--;
                if (m_hold == 0) m_phase = PRun;
            end
            PRun: begin
                if (cpu_halt) m_phase = PDone;
            end
            default: ;
        endcase
        model_outputs();
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (rst) model_reset();
            else model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    int          cyc = 0;
    int          last_wr_cyc = -1;
    int          rst_fall_cyc = -1;
    logic        prev_cpu_rst = 1'b1;
    logic [15:0] wlog[$];

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!rst) begin
                check("cyc in_ready", in_if.in_ready, e_ready);
                check("cyc mem_wr", mem_wr, e_wr);
                check("cyc cpu_rst", cpu_rst, e_rst);
                check("cyc mem_own", mem_own, e_own);
                check("cyc busy", busy, e_busy);
                check("cyc done", done, e_done);
                if (e_wr) begin
                    check("cyc mem_addr", mem_addr, e_addr);
                    check("cyc mem_data", mem_data, e_data);
                end
                if (mem_wr) begin
                    wlog.push_back(16'({mem_addr, mem_data}));
                    last_wr_cyc = cyc;
                end
                if (prev_cpu_rst && !cpu_rst) rst_fall_cyc = cyc;
            end
            prev_cpu_rst = cpu_rst;
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [DW-1:0] tx_q[$];

    task automatic fill_random(input int n);
        tx_q.delete();
        for (int i = 0; i < n; i++) tx_q.push_back(DW'($urandom));
    endtask

    task automatic do_start(input int l);
        @(negedge clk);
        start = 1'b1;
        len   = (AW + 1)'(l);
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode 0: back-to-back, 1: valid toggles 1-0-1-0, 2: random gaps.
    task automatic send_words(input int n, input int mode, input bit hold_after, input bit noise);
        int  idx = 0;
        int  tmo = 0;
        bit  tog = 1'b0;
        bit  vld;
        while (idx < n && tmo < 1000) begin
            case (mode)
                1:       vld = ~tog;
                2:       vld = ($urandom_range(0, 1) == 1);
                default: vld = 1'b1;
            endcase
            tog = ~tog;
            if (noise) start = ($urandom_range(0, 3) == 0);
            in_if.in_valid = vld;
            in_if.in_data  = vld ? tx_q[idx] : DW'($urandom);
            if (vld && in_if.in_ready) idx++;
            @(negedge clk);
            tmo++;
        end
        start = 1'b0;
        check("send words in budget", idx, n);
        if (hold_after) begin
            in_if.in_valid = 1'b1;
            in_if.in_data  = 8'hEE;
            repeat (6) @(negedge clk);
        end
        in_if.in_valid = 1'b0;
    endtask

    task automatic wait_run();
        int t = 0;
        while (cpu_rst !== 1'b0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("reach RUN in budget", (t < 100), 1);
    endtask

    task automatic halt_pulse(input int d, input bit noise);
        for (int i = 0; i < d; i++) begin
            @(negedge clk);
            start = noise ? ($urandom_range(0, 1) == 1) : 1'b0;
        end
        @(negedge clk);
        start    = 1'b0;
        cpu_halt = 1'b1;
        @(negedge clk);
        cpu_halt = 1'b0;
        check("halt done", done, 1);
        check("halt busy", busy, 0);
        check("halt cpu_rst", cpu_rst, 0);
        check("halt mem_own", mem_own, 0);
    endtask

    task automatic check_log(input int n);
        check("log count", wlog.size(), n);
        for (int i = 0; i < n && i < wlog.size(); i++) begin
            check("log addr", wlog[i][12:8], i);
            check("log data", wlog[i][7:0], tx_q[i]);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " in_ready"}, in_if.in_ready, 0);
        check({tag, " mem_wr"}, mem_wr, 0);
        check({tag, " mem_addr"}, mem_addr, 0);
        check({tag, " mem_data"}, mem_data, 0);
        check({tag, " cpu_rst"}, cpu_rst, 1);
        check({tag, " mem_own"}, mem_own, 1);
        check({tag, " busy"}, busy, 0);
        check({tag, " done"}, done, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        in_if.in_valid = 1'b0;
        in_if.in_data  = '0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst held");
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("idle");

        // Three words back-to-back, then check the reset release timing.
        tx_q = '{8'hA1, 8'hB2, 8'hC3};
        wlog.delete();
        do_start(3);
        send_words(3, 0, 1'b0, 1'b0);
        check("t1 ready low after last", in_if.in_ready, 0);
        wait_run();
        check_log(3);
        check("t1 cpu_rst fall delay", rst_fall_cyc - last_wr_cyc, HC);
        halt_pulse(10, 1'b0);

        // Full memory via len=0, alternating valid, valid left high afterwards.
        fill_random(FULL);
        wlog.delete();
        do_start(0);
        send_words(FULL, 1, 1'b1, 1'b0);
        check_log(FULL);
        wait_run();
        halt_pulse(10, 1'b0);

        // Full load with halt asserted during HOLD.
        fill_random(FULL);
        wlog.delete();
        do_start(0);
        send_words(FULL, 2, 1'b0, 1'b0);
        cpu_halt = 1'b1;
        @(negedge clk);
        @(negedge clk);
        cpu_halt = 1'b0;
        check("t3 busy in hold", busy, 1);
        check("t3 done in hold", done, 0);
        wait_run();
        check_log(FULL);
        halt_pulse(10, 1'b0);

        // Asynchronous reset after two of five words.
        fill_random(5);
        do_start(5);
        send_words(2, 0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1 check_reset_vals("async rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("after rst");
        fill_random(2);
        wlog.delete();
        do_start(2);
        send_words(2, 0, 1'b0, 1'b0);
        check_log(2);
        wait_run();
        halt_pulse(4, 1'b0);

        // Restart from DONE with a single word.
        check("t5 in done", done, 1);
        tx_q = '{8'h7F};
        wlog.delete();
        @(negedge clk);
        start = 1'b1;
        len   = 6'd1;
        @(posedge clk);
        #1;
        check("t5 cpu_rst at start", cpu_rst, 1);
        check("t5 mem_own at start", mem_own, 1);
        check("t5 in_ready at start", in_if.in_ready, 1);
        check("t5 done cleared", done, 0);
        @(negedge clk);
        start = 1'b0;
        send_words(1, 0, 1'b0, 1'b0);
        check_log(1);
        wait_run();
        halt_pulse(3, 1'b0);

        // Random loads with start noise during LOAD and RUN.
        for (int it = 0; it < 5; it++) begin
            int l;
            int n;
            l = $urandom_range(0, FULL);
            n = (l == 0) ? FULL : l;
            fill_random(n);
            wlog.delete();
            do_start(l);
            send_words(n, 2, ($urandom_range(0, 1) == 1), 1'b1);
            wait_run();
            check_log(n);
            halt_pulse($urandom_range(2, 12), 1'b1);
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/risc_boot_loader.md
Name: risc_boot_loader

Overview:
Upstream stage of the RISC core. It owns the core's memory write port and reset during program load.
- Accepts a stream of program words over a valid/ready handshake and writes them to consecutive memory addresses from 0.
- Holds the core in reset until loading completes, then releases it.
- Watches the core's halt output and reports completion.

Parameters:
AWIDTH, 5, memory address width (must match core)
DWIDTH, 8, memory data width (must match core)
HOLD_CYCLES, 4, cycles core reset stays asserted after the last write (≥1)

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  asynchronous active-high reset
start  in  1  single-cycle request to begin a load; honoured only in IDLE or DONE
len  in  AWIDTH+1  number of words to load, sampled with start; 0 means 2^AWIDTH
in_valid  in  1  upstream word valid
in_data  in  DWIDTH  upstream program word
in_ready  out  1  loader accepts a word this cycle
mem_addr  out  AWIDTH  memory write address (registered)
mem_data  out  DWIDTH  memory write data (registered)
mem_wr  out  1  memory write strobe (registered)
mem_own  out  1  loader owns memory bus; core muxes its addr/data/wr onto memory only when low
cpu_rst  out  1  reset to core, active-high
cpu_halt  in  1  halt from core
busy  out  1  high in LOAD, HOLD, RUN
done  out  1  high in DONE (core halted after a run)

Behaviour:
- Reset (async, any state, including mid-load): state=IDLE, cpu_rst=1, mem_own=1, mem_wr=0, mem_addr=0, mem_data=0, in_ready=0, busy=0, done=0, word and hold counters cleared.
- States: IDLE, LOAD, HOLD, RUN, DONE.
- IDLE:
  - cpu_rst=1, mem_own=1, in_ready=0.
  - start → LOAD; next write address=0; remaining=len (0 → 2^AWIDTH).
- LOAD:
  - in_ready=1 (registered, goes high the cycle after start).
  - Transfer occurs on a rising edge where in_valid&&in_ready.
  - For a transfer at edge k: mem_wr=1, mem_addr=current address, mem_data=in_data during cycle k..k+1, i.e. one-cycle write latency.
  - mem_wr=0 in cycles with no transfer.
  - Address increments by 1 per transfer; remaining decrements.
  - Back-to-back transfers sustain one word per cycle.
  - On the transfer of the last word: in_ready drops at that same edge, state → HOLD.
  - No word is accepted beyond len. in_valid held high after the last word is left pending upstream.
  - Address wrap (2^AWIDTH words) ends exactly at address 2^AWIDTH−1; no wrap to 0 occurs.
  - start ignored.
- HOLD:
  - cpu_rst=1, mem_own=1; the final mem_wr pulse completes in the first HOLD cycle.
  - Counts HOLD_CYCLES cycles, then → RUN.
  - cpu_halt ignored.
- RUN:
  - cpu_rst=0, mem_own=0, mem_wr=0, in_ready=0.
  - First cycle with cpu_halt=1 → DONE.
  - start ignored.
- DONE:
  - done=1; cpu_rst stays 0 so halted core state remains observable; mem_own=0.
  - start → LOAD with cpu_rst=1 and mem_own=1 asserted at the same edge.
- Simultaneous start and in_valid in IDLE/DONE: in_valid is not accepted that cycle (in_ready=0).
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package risc_boot_pkg holds:
  - state enum encoding (IDLE=0, LOAD=1, HOLD=2, RUN=3, DONE=4, 3 bits);
  - default AWIDTH/DWIDTH constants shared with the core.
- Address/remaining counting uses the team's existing parameterized counter module with load and enable, instantiated at width AWIDTH+1.
- Hold timer is a small inline down-counter.
- No further sub-modules.

Test Plan:
- Reset then start with len=3 and words 0xA1,0xB2,0xC3 streamed back-to-back → mem_wr high 3 consecutive cycles at addresses 0,1,2 with those data; in_ready low after third; cpu_rst falls exactly 4 cycles after last mem_wr cycle.
- len=0 with 32 words and in_valid toggled 1-0-1-0 → exactly 32 writes, addresses 0..31, no write when in_valid=0, no extra accept with in_valid held high afterward.
- Full load then cpu_halt pulsed 10 cycles into RUN → done=1 next cycle, busy=0, cpu_rst stays 0; cpu_halt asserted during HOLD ignored.
- Assert rst after 2 of 5 words accepted → all outputs at reset values immediately (asynchronous, before next clock edge); later start with len=2 restarts at address 0.
- In DONE, start with len=1 and word 0x7F → cpu_rst=1 and mem_own=1 same edge; single write at address 0 with data 0x7F.
- start pulsed during LOAD and RUN → no state change, address counter unaffected.
